// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding, opcode field position and fetch constants
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_e;

    localparam int          OPC_MSB         = 31;
    localparam int          OPC_LSB         = 26;
    localparam logic [5:0]  HALT_OPCODE_DEF = 6'b101101;
    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam int          MEM_DEPTH_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0;

    function automatic logic is_halt(input logic [31:0] inst, input logic [5:0] opc);
        return inst[OPC_MSB:OPC_LSB] == opc;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: loader, memory and IF/ID signals of the fetch controller
interface fetch_ctrl_if;

    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_err;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst_in;
    logic [31:0] pc;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        halted;
    logic        fetch_err;

    modport master (
        input  load_valid, load_data, start, stall, redirect_valid, redirect_pc, inst_in,
        output load_ready, load_err, pc, mem_we, mem_waddr, mem_wdata,
               if_valid, if_inst, if_pc, halted, fetch_err
    );

    modport slave (
        output load_valid, load_data, start, stall, redirect_valid, redirect_pc, inst_in,
        input  load_ready, load_err, pc, mem_we, mem_waddr, mem_wdata,
               if_valid, if_inst, if_pc, halted, fetch_err
    );

endinterface

// File: rtl/fetch_ctrl_prog_loader.sv
// prog_loader: streams program words into instruction memory through the write port
module prog_loader
    import fetch_ctrl_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic        load_valid_i,
    input  logic [31:0] load_data_i,
    output logic        load_ready_o,
    output logic        beat_o,
    output logic        mem_we_o,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic        load_err_o
);

    localparam int PW = $clog2(MEM_DEPTH + 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;

    // write-port drive is combinational so a beat lands in memory in its own cycle
    always_comb begin
        load_ready_o = enable_i && (ptr_q < PW'(MEM_DEPTH));
        beat_o       = load_valid_i && load_ready_o;
        mem_we_o     = beat_o;
        mem_waddr_o  = beat_o ? 32'(ptr_q) << 2 : 32'h0;
        mem_wdata_o  = beat_o ? load_data_i : 32'h0;
        ptr_d        = beat_o ? ptr_q + PW'(1) : (clear_i ? '0 : ptr_q);
        err_d        = err_q || (enable_i && load_valid_i && !load_ready_o);
    end

    // pointer rewinds on start so the next program overwrites from address 0
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign load_err_o = err_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-memory sequencer with program load, fetch, stall, redirect and halt
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    localparam logic [31:0] FETCH_LIMIT = 32'(MEM_DEPTH * 4);

    state_e      state_q;
    logic [31:0] pc_q, if_inst_q, if_pc_q;
    logic        if_valid_q, halted_q, fetch_err_q;
    logic        running, beat, go;

    assign running = state_q == RUN;
    assign go      = !running && bus.start && !beat;

    prog_loader #(.MEM_DEPTH(MEM_DEPTH)) u_loader (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (!running),
        .clear_i      (go),
        .load_valid_i (bus.load_valid),
        .load_data_i  (bus.load_data),
        .load_ready_o (bus.load_ready),
        .beat_o       (beat),
        .mem_we_o     (bus.mem_we),
        .mem_waddr_o  (bus.mem_waddr),
        .mem_wdata_o  (bus.mem_wdata),
        .load_err_o   (bus.load_err)
    );

    // sequencer: a load beat beats start; in RUN redirect beats stall beats normal fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_inst_q   <= 32'h0;
            if_pc_q     <= 32'h0;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else if (!running) begin
            if_valid_q <= 1'b0;
            if (beat) begin
                state_q <= LOAD;
            end else if (bus.start) begin
                state_q  <= RUN;
                pc_q     <= RESET_PC;
                halted_q <= 1'b0;
            end
        end else if (bus.redirect_valid) begin
            pc_q       <= bus.redirect_pc & ~32'h3;
            if_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            if (pc_q >= FETCH_LIMIT) begin
                if_valid_q  <= 1'b0;
                fetch_err_q <= 1'b1;
                halted_q    <= 1'b1;
                state_q     <= HALT;
            end else begin
                if_inst_q  <= bus.inst_in;
                if_pc_q    <= pc_q;
                if_valid_q <= 1'b1;
                if (is_halt(bus.inst_in, HALT_OPCODE)) begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end else begin
                    pc_q <= pc_q + PC_STEP;
                end
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.halted    = halted_q;
    assign bus.fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random stimulus checked against a behavioural fetch model
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    logic [31:0] mem [32];

    always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr[6:2]] <= bus.mem_wdata;

    assign bus.inst_in = (bus.pc < 32'd128) ? mem[bus.pc[6:2]] : 32'h0;

    int          m_mode;
    int          m_ptr;
    logic [31:0] m_pc, m_inst, m_ifpc;
    logic        m_valid, m_halted, m_ferr, m_lerr;
    logic [31:0] m_mem [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] plain_word();
        logic [31:0] w = $urandom;
        if (w[31:26] == 6'b101101) w[31] = 1'b0;
        return w;
    endfunction

    task automatic model_edge();
        logic [31:0] w;
        bit took = 0;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_ptr = 0; m_valid = 0; m_inst = 0; m_ifpc = 0;
            m_halted = 0; m_ferr = 0; m_lerr = 0;
        end else if (m_mode != 2) begin
            if (bus.load_valid) begin
                if (m_ptr < 32) begin
                    m_mem[m_ptr] = bus.load_data;
                    m_ptr++;
                    m_mode = 1;
                    took = 1;
                end else m_lerr = 1;
            end
            m_valid = 0;
            if (bus.start && !took) begin
                m_mode = 2; m_pc = 0; m_ptr = 0; m_halted = 0;
            end
        end else if (bus.redirect_valid) begin
            m_pc = bus.redirect_pc & ~32'h3;
            m_valid = 0;
        end else if (!bus.stall) begin
            if (m_pc >= 128) begin
                m_valid = 0; m_ferr = 1; m_halted = 1; m_mode = 3;
            end else begin
                w = m_mem[m_pc / 4];
                m_inst = w; m_ifpc = m_pc; m_valid = 1;
                if (w[31:26] == 6'd45) begin
                    m_mode = 3; m_halted = 1;
                end else m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic step();
        bit exp_ready, exp_we;
        @(negedge clk);
        exp_ready = (m_mode != 2) && (m_ptr < 32);
        exp_we    = exp_ready && bus.load_valid;
        chk("load_ready", 32'(bus.load_ready), 32'(exp_ready));
        chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
        if (exp_we) begin
            chk("mem_waddr", bus.mem_waddr, 32'(m_ptr * 4));
            chk("mem_wdata", bus.mem_wdata, bus.load_data);
        end
        model_edge();
        @(posedge clk);
        #1;
        chk("pc", bus.pc, m_pc);
        chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
        chk("if_inst", bus.if_inst, m_inst);
        chk("if_pc", bus.if_pc, m_ifpc);
        chk("halted", 32'(bus.halted), 32'(m_halted));
        chk("fetch_err", 32'(bus.fetch_err), 32'(m_ferr));
        chk("load_err", 32'(bus.load_err), 32'(m_lerr));
    endtask

    task automatic quiet();
        rst = 0; bus.load_valid = 0; bus.load_data = 0; bus.start = 0;
        bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0;
            m_mem[i] = 32'h0;
        end
        m_mode = 0; m_ptr = 0; m_pc = 0; m_inst = 0; m_ifpc = 0;
        m_valid = 0; m_halted = 0; m_ferr = 0; m_lerr = 0;
        quiet();
        rst = 1;
        step();
        step();
        quiet();
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_if_valid", 32'(bus.if_valid), 32'h0);

        for (int i = 0; i < 11; i++) begin
            bus.load_valid = 1;
            bus.load_data = (i == 10) ? 32'hB4221820 : plain_word();
            step();
        end
        quiet();
        bus.start = 1;
        step();
        quiet();
        for (int i = 0; i < 13; i++) step();
        chk("halt_word_pc", bus.if_pc, 32'd40);
        chk("halt_flag", 32'(bus.halted), 32'h1);

        bus.start = 1;
        step();
        quiet();
        step();
        step();
        chk("pre_stall_pc", bus.pc, 32'd8);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) step();
        chk("stall_pc_hold", bus.pc, 32'd8);
        bus.stall = 0;
        step();
        chk("release_if_pc", bus.if_pc, 32'd8);
        step();
        chk("release_if_pc2", bus.if_pc, 32'd12);
        bus.stall = 1;
        bus.redirect_valid = 1;
        bus.redirect_pc = 32'h6;
        step();
        quiet();
        chk("redirect_pc", bus.pc, 32'd4);
        chk("redirect_flush", 32'(bus.if_valid), 32'h0);
        step();
        chk("redirect_if_pc", bus.if_pc, 32'd4);

        rst = 1;
        step();
        quiet();
        for (int i = 0; i < 33; i++) begin
            bus.load_valid = 1;
            bus.load_data = plain_word();
            step();
        end
        quiet();
        chk("overflow_err", 32'(bus.load_err), 32'h1);
        bus.start = 1;
        step();
        quiet();
        for (int i = 0; i < 34; i++) step();
        chk("range_ferr", 32'(bus.fetch_err), 32'h1);
        chk("range_halted", 32'(bus.halted), 32'h1);
        chk("range_if_valid", 32'(bus.if_valid), 32'h0);
        bus.start = 1;
        step();
        quiet();
        chk("restart_pc", bus.pc, 32'h0);
        chk("restart_halted", 32'(bus.halted), 32'h0);

        for (int i = 0; i < 5; i++) step();
        rst = 1;
        step();
        quiet();
        chk("midrun_reset_pc", bus.pc, 32'h0);
        bus.start = 1;
        step();
        quiet();
        for (int i = 0; i < 3; i++) step();

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.start = ($urandom_range(0, 15) == 0);
            bus.load_valid = $urandom_range(0, 1) == 1;
            bus.load_data = plain_word();
            if ($urandom_range(0, 7) == 0) bus.load_data[31:26] = 6'b101101;
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.redirect_valid = ($urandom_range(0, 7) == 0);
            bus.redirect_pc = 32'($urandom_range(0, 140));
            step();
        end
        quiet();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
